// File: rtl/oro_pkg.sv
// oro_pkg: shared defaults, entry layout and width helper for the event capture block
package oro_pkg;
  localparam int ORO_DATA_W = 8;
  localparam int ORO_TS_W = 16;
  localparam int ORO_DEPTH = 8;
  localparam int ORO_ENTRY_W = ORO_TS_W + ORO_DATA_W;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/oro_event_capture_if.sv
// oro_event_capture_if: event input, drain port and status of the capture FIFO
interface oro_event_capture_if
  import oro_pkg::*;
#(
  parameter int DATA_W = ORO_DATA_W,
  parameter int DEPTH = ORO_DEPTH,
  parameter int TS_W = ORO_TS_W
) ();
  localparam int CW = clog2(DEPTH) + 1;
  logic evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic rd_ready;
  logic rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0] rd_ts;
  logic [CW-1:0] count;
  logic overflow;
  logic clr_ovf;
  modport master (
    output evt_valid, evt_data, rd_ready, clr_ovf,
    input rd_valid, rd_data, rd_ts, count, overflow
  );
  modport slave (
    input evt_valid, evt_data, rd_ready, clr_ovf,
    output rd_valid, rd_data, rd_ts, count, overflow
  );
endinterface

// File: rtl/oro_sync_fifo.sv
// oro_sync_fifo: first-word-fall-through storage with same-cycle push/pop and occupancy count
module oro_sync_fifo
  import oro_pkg::*;
#(
  parameter int WIDTH = ORO_ENTRY_W,
  parameter int DEPTH = ORO_DEPTH,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0] o_count,
  output logic o_full,
  output logic o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  // Full/empty come from the count; pointers are equal in both cases
  always_ff @(posedge clk) begin
    r_wr_ptr <= !rst_n ? '0 : i_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
    r_rd_ptr <= !rst_n ? '0 : i_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    r_count <= !rst_n ? '0 : r_count + CW'(i_push) - CW'(i_pop);
  end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/oro_event_capture.sv
// oro_event_capture: cycle-timestamped event FIFO with sticky overflow and valid/ready drain
module oro_event_capture
  import oro_pkg::*;
#(
  parameter int DATA_W = ORO_DATA_W,
  parameter int DEPTH = ORO_DEPTH,
  parameter int TS_W = ORO_TS_W
) (
  input logic clk,
  input logic rst_n,
  oro_event_capture_if.slave bus
);
  localparam int EW = TS_W + DATA_W;
  localparam int CW = clog2(DEPTH) + 1;
  logic [TS_W-1:0] r_cyc;
  logic r_ovf;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic [EW-1:0] w_head;
  logic [CW-1:0] w_count;
  assign w_pop = !w_empty && bus.rd_ready;
  assign w_push = bus.evt_valid && (!w_full || w_pop);
  assign w_drop = bus.evt_valid && w_full && !w_pop;
  // A drop at the same edge as clr_ovf keeps the flag set
  always_ff @(posedge clk) begin
    r_cyc <= !rst_n ? '0 : r_cyc + 1'b1;
    r_ovf <= !rst_n ? 1'b0 : w_drop ? 1'b1 : bus.clr_ovf ? 1'b0 : r_ovf;
  end
  oro_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_wdata({r_cyc, bus.evt_data}),
    .o_rdata(w_head),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign bus.rd_valid = !w_empty;
  assign bus.rd_data = w_empty ? '0 : w_head[DATA_W-1:0];
  assign bus.rd_ts = w_empty ? '0 : w_head[EW-1 -: TS_W];
  assign bus.count = w_count;
  assign bus.overflow = r_ovf;
endmodule
